// File: rtl/bram_fifo_seq_ctrl.sv
// Sequencer and enable guard for the shared FIFO_SYNC_MACRO slices behind fifo_v3.
// It runs the macro reset sequence, masks WREN/RDEN around RST and tracks exact occupancy.
module bram_fifo_seq_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int PRE_CYCLES  = 4,
    parameter int RST_CYCLES  = 5,
    parameter int POST_CYCLES = 4,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rst_o,
    output logic             fifo_wren_o,
    output logic             fifo_rden_o,
    output logic             ready_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] usage_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int SEQ_MAX = (PRE_CYCLES > RST_CYCLES)
                           ? ((PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES)
                           : ((RST_CYCLES > POST_CYCLES) ? RST_CYCLES : POST_CYCLES);
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    typedef enum logic [1:0] {
        S_PRE,
        S_RST,
        S_POST,
        S_RUN
    } state_t;

    state_t             state_reg;
    logic [SEQ_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   usage_reg;
    logic               fifo_rst_reg;
    logic               ready_reg;
    logic               overflow_reg;
    logic               underflow_reg;

    logic               run;
    logic               acc_push;
    logic               acc_pop;
    logic               drop_push;
    logic               drop_pop;

    // Flags and enables are decoded from registered state so the macros never see
    // an enable outside RUN; a flush cycle masks both enables.
    always_comb begin
        run       = (state_reg == S_RUN);
        full_o    = ~run | fifo_full_i  | (usage_reg == CNT_W'(DEPTH));
        empty_o   = ~run | fifo_empty_i | (usage_reg == '0);
        acc_push  = run & ~flush_i & push_i & ~full_o;
        acc_pop   = run & ~flush_i & pop_i  & ~empty_o;
        drop_push = run & ~flush_i & push_i & full_o;
        drop_pop  = run & ~flush_i & pop_i  & empty_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= S_PRE;
            cnt_reg       <= SEQ_W'(PRE_CYCLES - 1);
            usage_reg     <= '0;
            fifo_rst_reg  <= 1'b0;
            ready_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= drop_push;
            underflow_reg <= drop_pop;
            case (state_reg)
                S_PRE: begin
                    if (cnt_reg == '0) begin
                        state_reg    <= S_RST;
                        cnt_reg      <= SEQ_W'(RST_CYCLES - 1);
                        fifo_rst_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_RST: begin
                    if (cnt_reg == '0) begin
                        state_reg    <= S_POST;
                        cnt_reg      <= SEQ_W'(POST_CYCLES - 1);
                        fifo_rst_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_POST: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_RUN;
                        ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        state_reg <= S_PRE;
                        cnt_reg   <= SEQ_W'(PRE_CYCLES - 1);
                        ready_reg <= 1'b0;
                        usage_reg <= '0;
                    end else begin
                        usage_reg <= usage_reg + CNT_W'(acc_push) - CNT_W'(acc_pop);
                    end
                end
                default: state_reg <= S_PRE;
            endcase
        end
    end

    assign fifo_rst_o  = fifo_rst_reg;
    assign fifo_wren_o = acc_push;
    assign fifo_rden_o = acc_pop;
    assign ready_o     = ready_reg;
    assign usage_o     = usage_reg;
    assign overflow_o  = overflow_reg;
    assign underflow_o = underflow_reg;

endmodule

// File: tb/tb_bram_fifo_seq_ctrl.sv
// Scoreboard bench for bram_fifo_seq_ctrl: stimulus queues expected observations,
// a negedge monitor pops and compares them.
module tb_bram_fifo_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        push_i = 1'b0;
    logic        pop_i = 1'b0;
    logic        fifo_full_i = 1'b0;
    logic        fifo_empty_i = 1'b0;
    logic        fifo_rst_o;
    logic        fifo_wren_o;
    logic        fifo_rden_o;
    logic        ready_o;
    logic        full_o;
    logic        empty_o;
    logic [10:0] usage_o;
    logic        overflow_o;
    logic        underflow_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        frst;
        logic        wren;
        logic        rden;
        logic        ready;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
        logic [10:0] usage;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];

    bram_fifo_seq_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .push_i       (push_i),
        .pop_i        (pop_i),
        .fifo_full_i  (fifo_full_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rst_o   (fifo_rst_o),
        .fifo_wren_o  (fifo_wren_o),
        .fifo_rden_o  (fifo_rden_o),
        .ready_o      (ready_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .usage_o      (usage_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic obs_t mk(input bit frst, wren, rden, ready, full, empty, ovf, unf,
                                input int usage);
        obs_t o;
        o = '{frst, wren, rden, ready, full, empty, ovf, unf, 11'(usage)};
        return o;
    endfunction

    function automatic obs_t run_exp(input bit wren, rden, full, empty, ovf, unf, input int usage);
        return mk(1'b0, wren, rden, 1'b1, full, empty, ovf, unf, usage);
    endfunction

    // Called just after a rising edge: drive this cycle's inputs, queue the expectation,
    // then advance to just after the next rising edge.
    task automatic vec(input string nm, input bit p, input bit po, input bit fl, input obs_t e);
        push_i  = p;
        pop_i   = po;
        flush_i = fl;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk_i);
        #1;
    endtask

    // Cycle 0 is the first cycle in PRE; push/pop/flush are held active to show they are ignored.
    task automatic reset_seq(input string tag);
        for (int c = 0; c < 13; c++)
            vec($sformatf("%s_seq%0d", tag, c), 1'b1, 1'b1, 1'(c % 2),
                mk(c >= 4 && c <= 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
        vec($sformatf("%s_ready", tag), 1'b0, 1'b0, 1'b0, run_exp(0, 0, 0, 1, 0, 0, 0));
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  got;
            string nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = '{fifo_rst_o, fifo_wren_o, fifo_rden_o, ready_o, full_o, empty_o,
                    overflow_o, underflow_o, usage_o};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s got{rst,wr,rd,rdy,full,empty,ovf,unf}=%b usage=%0d exp=%b usage=%0d",
                         nm, got[18:11], got.usage, e[18:11], e.usage);
            end else begin
                $display("ok   %s flags=%b usage=%0d", nm, got[18:11], got.usage);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        reset_seq("init");

        // Fill to DEPTH, then the extra push is dropped
        for (int i = 0; i < 1024; i++)
            vec($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b0, run_exp(1, 0, 0, i == 0, 0, 0, i));
        vec("push_full", 1'b1, 1'b0, 1'b0, run_exp(0, 0, 1, 0, 0, 0, 1024));
        vec("ovf_pulse", 1'b0, 1'b0, 1'b0, run_exp(0, 0, 1, 0, 1, 0, 1024));

        // Full with push+pop: only the pop goes through
        vec("full_pushpop", 1'b1, 1'b1, 1'b0, run_exp(0, 1, 1, 0, 0, 0, 1024));
        vec("full_pushpop_after", 1'b0, 1'b0, 1'b0, run_exp(0, 0, 0, 0, 1, 0, 1023));

        for (int i = 0; i < 1020; i++)
            vec($sformatf("drain%0d", i), 1'b0, 1'b1, 1'b0, run_exp(0, 1, 0, 0, 0, 0, 1023 - i));
        for (int i = 0; i < 10; i++)
            vec($sformatf("steady%0d", i), 1'b1, 1'b1, 1'b0, run_exp(1, 1, 0, 0, 0, 0, 3));
        for (int i = 0; i < 3; i++)
            vec($sformatf("empty_out%0d", i), 1'b0, 1'b1, 1'b0, run_exp(0, 1, 0, 0, 0, 0, 3 - i));
        vec("empty_pushpop", 1'b1, 1'b1, 1'b0, run_exp(1, 0, 0, 1, 0, 0, 0));
        vec("unf_pulse", 1'b0, 1'b0, 1'b0, run_exp(0, 0, 0, 0, 0, 1, 1));

        // Flush at usage 500 wins over a simultaneous push
        for (int i = 0; i < 499; i++)
            vec($sformatf("refill%0d", i), 1'b1, 1'b0, 1'b0, run_exp(1, 0, 0, 0, 0, 0, 1 + i));
        vec("flush", 1'b1, 1'b0, 1'b1, run_exp(0, 0, 0, 0, 0, 0, 500));
        reset_seq("flush");

        // Slice flags alone must block the enables
        vec("one_push", 1'b1, 1'b0, 1'b0, run_exp(1, 0, 0, 1, 0, 0, 0));
        fifo_empty_i = 1'b1;
        vec("flag_empty", 1'b0, 1'b1, 1'b0, run_exp(0, 0, 0, 1, 0, 0, 1));
        fifo_empty_i = 1'b0;
        fifo_full_i  = 1'b1;
        vec("flag_full", 1'b1, 1'b0, 1'b0, run_exp(0, 0, 1, 0, 0, 1, 1));
        fifo_full_i  = 1'b0;
        vec("flag_full_after", 1'b0, 1'b0, 1'b0, run_exp(0, 0, 0, 0, 1, 0, 1));

        // Async reset in the middle of RST
        vec("flush2", 1'b0, 1'b0, 1'b1, run_exp(0, 0, 0, 0, 0, 0, 1));
        for (int c = 0; c < 6; c++)
            vec($sformatf("abort_seq%0d", c), 1'b0, 1'b0, 1'b0,
                mk(c >= 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
        checks++;
        if (fifo_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got fifo_rst_o=%b exp=1", fifo_rst_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (fifo_rst_o !== 1'b0 || ready_o !== 1'b0 || full_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_async got rst/ready/full=%b%b%b exp=001", fifo_rst_o, ready_o, full_o);
        end else begin
            $display("ok   abort_async fifo_rst_o dropped");
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        reset_seq("abort");

        @(posedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
